// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and helpers for the line-granular memory responder
//
// Contents:
//   state_e        responder FSM states
//   LINE_BYTES     bytes per cache line
//   LINE_OFFSET_W  byte-offset bits inside a line
//   line_index()   byte address -> line index, wrapped to the array depth
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int LINE_BYTES    = 32;
    localparam int LINE_OFFSET_W = 5;

    // Drops the byte offset and masks off everything above the array depth,
    // so addresses alias modulo depth*LINE_BYTES. depth must be a power of two.
    function automatic logic [31:0] line_index(input logic [63:0] addr,
                                               input int unsigned depth);
        logic [63:0] mask;
        mask = 64'(depth) - 64'd1;
        return 32'((addr >> LINE_OFFSET_W) & mask);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port DEPTH x DATA_W synchronous line store
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (clears read register only)
//   en_i     perform an access at this edge
//   we_i     write when en_i is high (read otherwise)
//   idx_i    line index
//   wdata_i  write line
//   rdata_o  registered read line; on a write it returns the written line
module mem_line_array
    import mem_if_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Write-through on the read port so a write completion echoes its data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_latency_responder.sv
// rtl/mem_latency_responder.sv - fixed-latency line memory for cache refill/write-back
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   enable_i  request valid, held by requestor until ack_o
//   write_i   1 = line write, 0 = line read (sampled with enable_i)
//   addr_i    byte address, bits [4:0] ignored, high bits wrap
//   data_i    write line
//   ack_o     one-cycle completion pulse
//   data_o    read line, valid while ack_o is high
//   busy_o    high from acceptance through the ack cycle
module mem_latency_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
            $fatal(1, "mem_latency_responder: LATENCY must be within 1..255");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "mem_latency_responder: DEPTH must be a power of two");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              access;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    wr_d    = write_i;
                    idx_d   = IDX_W'(line_index(64'(addr_i), DEPTH));
                    wdata_d = data_i;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // The array commits/reads on this same edge.
                    access  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // enable_i is ignored here; a still-held request is seen in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decoded straight from the state register, so both are glitch-free.
    assign ack_o  = (state_q == ACK);
    assign busy_o = (state_q != IDLE);

    mem_line_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (access),
        .we_i    (access && wr_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_mem_latency_responder.sv
// tb/tb_mem_latency_responder.sv - randomized self-checking bench for mem_latency_responder
module tb_mem_latency_responder;

    localparam int DW  = 256;
    localparam int AW  = 32;
    localparam int DEP = 512;
    localparam int LAT = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          en = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ack, busy;
    logic [DW-1:0] dout;

    logic          en1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          ack1, busy1;
    logic [DW-1:0] dout1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: plain array indexed by (byte address / 32) mod DEP.
    logic [DW-1:0] model [DEP];

    always #5 clk = ~clk;

    mem_latency_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(wdata), .ack_o(ack), .data_o(dout), .busy_o(busy)
    );

    mem_latency_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
        .data_i(wdata1), .ack_o(ack1), .data_o(dout1), .busy_o(busy1)
    );

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a / 32) % DEP);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Address of line idx with random offset bits and random aliasing high bits.
    function automatic logic [31:0] alias_addr(input int idx);
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'h0000_3FE0) | (32'(idx) << 5);
    endfunction

    // One transaction on the LATENCY=LAT instance with cycle-exact checks.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [DW-1:0] wd,
                          input bit scramble, input string name);
        logic [DW-1:0] exp_rd;
        int idx;
        idx = ref_idx(a);
        exp_rd = w ? wd : model[idx];
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdata = wd;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (scramble) begin
                addr  = $urandom;
                wdata = rand_line();
                wr    = 1'(($urandom) & 1);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
            end
            n_cmp++;
            if (ack !== (k == LAT + 1)) begin
                n_bad++;
                $display("FAIL %s ack cycle %0d: got %b want %b", name, k, ack, (k == LAT + 1));
            end
            if (k == LAT + 1) begin
                n_cmp++;
                if (dout !== exp_rd) begin
                    n_bad++;
                    $display("FAIL %s data: got %h want %h", name, dout, exp_rd);
                end
                en = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after-ack idle: got busy=%b ack=%b want 0 0", name, busy, ack);
        end
        if (w) model[idx] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
            n_bad++;
            $display("FAIL reset: got ack=%b busy=%b data=%h want 0 0 0", ack, busy, dout);
        end
        n_cmp++;
        if (ack1 !== 1'b0 || busy1 !== 1'b0 || dout1 !== '0) begin
            n_bad++;
            $display("FAIL reset_lat1: got ack=%b busy=%b data=%h want 0 0 0", ack1, busy1, dout1);
        end
        rst = 1'b0;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 16; i++) begin
            do_txn(1'b1, alias_addr(i), rand_line(), 1'b0, "preload");
        end
    endtask

    task automatic test_read_basic();
        do_txn(1'b1, 32'h60, {32{8'hA5}}, 1'b0, "write_a5");
        do_txn(1'b0, 32'h60, '0, 1'b0, "read_a5");
    endtask

    task automatic test_offset_ignore();
        do_txn(1'b1, 32'h80, {8{32'h1234_5678}}, 1'b0, "write_1234");
        do_txn(1'b0, 32'h9F, '0, 1'b0, "read_offset");
    endtask

    task automatic test_wrap();
        do_txn(1'b0, 32'h4060, '0, 1'b0, "read_wrap");
    endtask

    task automatic test_scramble();
        do_txn(1'b1, 32'hE0, rand_line(), 1'b1, "write_scrambled");
        for (int i = 0; i < 16; i++) begin
            do_txn(1'b0, alias_addr(i), '0, 1'b0, "scan_after_scramble");
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h120; wdata = ~model[9];
        // Six cycles after acceptance the down-counter holds 4.
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ack !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
            n_bad++;
            $display("FAIL midflight_reset: got ack=%b busy=%b data=%h want 0 0 0", ack, busy, dout);
        end
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_no_ack: got %b want 0", ack);
        end
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_idle: got busy=%b ack=%b want 0 0", busy, ack);
        end
        do_txn(1'b0, 32'h120, '0, 1'b0, "read_after_drop");
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            if (($urandom & 1) != 0)
                do_txn(1'b1, alias_addr(idx), rand_line(), 1'b0, "rand_write");
            else
                do_txn(1'b0, alias_addr(idx), '0, 1'b0, "rand_read");
        end
    endtask

    // LATENCY=1 with enable held: request j alternates write/read of line 20+j/2.
    task automatic test_back_to_back();
        logic [DW-1:0] lines [8];
        int j;
        for (int i = 0; i < 8; i++) lines[i] = rand_line();
        j = 0;
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b1; addr1 = alias_addr(20); wdata1 = lines[0];
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ack1 !== (k % 3 == 2)) begin
                n_bad++;
                $display("FAIL b2b ack cycle %0d: got %b want %b", k, ack1, (k % 3 == 2));
            end
            n_cmp++;
            if (busy1 !== (k % 3 != 0)) begin
                n_bad++;
                $display("FAIL b2b busy cycle %0d: got %b want %b", k, busy1, (k % 3 != 0));
            end
            if (k % 3 == 2) begin
                n_cmp++;
                if (dout1 !== lines[j / 2]) begin
                    n_bad++;
                    $display("FAIL b2b data req %0d: got %h want %h", j, dout1, lines[j / 2]);
                end
                j++;
                wr1    = ((j % 2) == 0);
                addr1  = alias_addr(20 + j / 2);
                wdata1 = ((j % 2) == 0) ? lines[j / 2] : rand_line();
            end
        end
        en1 = 1'b0;
        n_cmp++;
        if (j != 6) begin
            n_bad++;
            $display("FAIL b2b completions: got %0d want 6", j);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_basic();
        test_offset_ignore();
        test_wrap();
        test_scramble();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
